// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : START/READY/DONE handshake and operand/result bus for the
//               bit-serial adder. The SUB signal exists only when the
//               SERIAL_ADDER_SUB_EN macro is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_IN;
`ifdef SERIAL_ADDER_SUB_EN
    logic             SUB;
`endif
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] S;
    logic             C_OUT;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output START, A, B, C_IN, SUB,
        input  READY, BUSY, DONE, S, C_OUT
    );
    modport slave (
        input  START, A, B, C_IN, SUB,
        output READY, BUSY, DONE, S, C_OUT
    );
`else
    modport master (
        output START, A, B, C_IN,
        input  READY, BUSY, DONE, S, C_OUT
    );
    modport slave (
        input  START, A, B, C_IN,
        output READY, BUSY, DONE, S, C_OUT
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (plus the full_adder cell it reuses)
// Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//               accepted START, summed LSB-first one bit per clock through a
//               single full_adder with a registered carry, and the result is
//               published with a one-cycle DONE pulse.
//               Optional macro SERIAL_ADDER_SUB_EN adds a SUB input that turns
//               the operation into A - B (C_OUT=1 means no borrow).
// Revision    : 1.0  initial release
// ============================================================================

// Single-bit full adder cell.
module full_adder (
    output logic S,
    output logic C_OUT,
    input  wire  A,
    input  wire  B,
    input  wire  C_IN
);
    // Sum and majority carry.
    assign S     = A ^ B ^ C_IN;
    assign C_OUT = (A & B) | (A & C_IN) | (B & C_IN);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire                 CLK,
    input  wire                 RST,
    serial_adder_ctrl_if.slave  bus
);
    // Counter is at least one bit wide so WIDTH=1 has a legal, non-wrapping
    // last-bit compare (0 == 0).
    localparam int               c_cnt_w   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic               r_c_out;

    logic               w_fa_s;
    logic               w_fa_c;
    logic [WIDTH-1:0]   w_sum_next;
    logic [WIDTH-1:0]   w_b_cap;
    logic               w_c_cap;

    full_adder u_fa (
        .S     (w_fa_s),
        .C_OUT (w_fa_c),
        .A     (r_a_sh[0]),
        .B     (r_b_sh[0]),
        .C_IN  (r_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_fa_s;
        end else begin : g_sum_wn
            assign w_sum_next = {w_fa_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // Operand/carry values to capture on an accepted START.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_cap = bus.SUB ? ~bus.B : bus.B;
    assign w_c_cap = bus.SUB ? 1'b1   : bus.C_IN;
`else
    assign w_b_cap = bus.B;
    assign w_c_cap = bus.C_IN;
`endif

    // Control FSM and datapath with registered handshake/result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    // Publishing the result and accepting a new START can
                    // share this edge, giving back-to-back operation.
                    if (r_state == ST_FIN) begin
                        r_s     <= r_sum;
                        r_c_out <= r_carry;
                        r_done  <= 1'b1;
                    end
                    if (bus.START) begin
                        r_a_sh  <= bus.A;
                        r_b_sh  <= w_b_cap;
                        r_carry <= w_c_cap;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_fa_c;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= ST_FIN;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.READY = r_ready;
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.S     = r_s;
    assign bus.C_OUT = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8). Vector
//               table plus hand-written corner sequences; expected results are
//               queued on each accepted START and compared on DONE.
//               Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W:0] sb_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_s;
        logic         exp_c;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Result monitor: every DONE must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.DONE === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [W:0] e;
                    e = sb_q.pop_front();
                    chk("sum", 32'(bus.S), 32'(e[W-1:0]));
                    chk("cout", 32'(bus.C_OUT), 32'(e[W]));
                end
            end
        end
    end

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub);
        bus.A    = a;
        bus.B    = b;
        bus.C_IN = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.SUB  = sub;
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // One full operation with latency, BUSY length and result-hold checks.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec);
        int n;
        int busy_n;
        bit seen;
        chk("ready_before_start", 32'(bus.READY), 32'd1);
        drive_ops(a, b, cin, sub);
        bus.START = 1'b1;
        sb_q.push_back({ec, es});
        @(posedge clk); #1;
        bus.START = 1'b0;
        busy_n = (bus.BUSY === 1'b1) ? 1 : 0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.DONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.BUSY === 1'b1) busy_n++;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("done_latency", 32'(n), 32'(W + 1));
        chk("busy_cycles", 32'(busy_n), 32'(W));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("hold_s", 32'(bus.S), 32'(es));
        chk("hold_cout", 32'(bus.C_OUT), 32'(ec));
        chk("done_single_pulse", 32'(bus.DONE), 32'd0);
        chk("ready_after", 32'(bus.READY), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp_s: 8'h00, exp_c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_s: 8'h00, exp_c: 1'b1};
        vecs[2] = '{a: 8'h5A, b: 8'hA5, cin: 1'b1, exp_s: 8'h00, exp_c: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_s: 8'hFF, exp_c: 1'b1};
        vecs[4] = '{a: 8'h12, b: 8'h34, cin: 1'b0, exp_s: 8'h46, exp_c: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b1, exp_s: 8'h01, exp_c: 1'b1};

        rst = 1'b1;
        bus.START = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.READY), 32'd1);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_s", 32'(bus.S), 32'd0);
        chk("rst_cout", 32'(bus.C_OUT), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors.
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].exp_s, vecs[i].exp_c);

        // A few random operands checked against bench arithmetic.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            logic [W:0] sum;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(1));
            sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op(ra, rb, rc, 1'b0, sum[W-1:0], sum[W]);
        end

        // START mid-RUN is ignored; START held through FIN is accepted.
        begin
            bit seen;
            drive_ops(8'h0F, 8'h01, 1'b0, 1'b0);
            bus.START = 1'b1;
            sb_q.push_back({1'b0, 8'h10});
            @(posedge clk); #1;
            bus.START = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            chk("busy_mid_run", 32'(bus.BUSY), 32'd1);
            drive_ops(8'hFF, 8'h01, 1'b0, 1'b0);
            bus.START = 1'b1;
            @(posedge clk); #1;
            drive_ops(8'h01, 8'h01, 1'b0, 1'b0);
            seen = 1'b0;
            for (int i = 0; i < 3 * W; i++) begin
                if (bus.READY === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!seen) chk("fin_timeout", 32'd0, 32'd1);
            chk("fin_not_done_yet", 32'(bus.DONE), 32'd0);
            sb_q.push_back({1'b0, 8'h02});
            @(posedge clk); #1;
            bus.START = 1'b0;
            chk("b2b_done", 32'(bus.DONE), 32'd1);
            chk("b2b_busy", 32'(bus.BUSY), 32'd1);
            seen = 1'b0;
            for (int i = 0; i < 3 * W; i++) begin
                @(posedge clk); #1;
                if (bus.DONE === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) chk("b2b_timeout", 32'd0, 32'd1);
            chk("b2b_s", 32'(bus.S), 32'h02);
            repeat (2) begin @(posedge clk); #1; end
        end

        // Reset in RUN cycle 4 discards the result; RST beats START.
        begin
            int dn;
            drive_ops(8'h33, 8'h44, 1'b0, 1'b0);
            bus.START = 1'b1;
            @(posedge clk); #1;
            bus.START = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b1;
            bus.START = 1'b1;
            @(posedge clk); #1;
            chk("midrst_ready", 32'(bus.READY), 32'd1);
            chk("midrst_busy", 32'(bus.BUSY), 32'd0);
            chk("midrst_done", 32'(bus.DONE), 32'd0);
            chk("midrst_s", 32'(bus.S), 32'd0);
            chk("midrst_cout", 32'(bus.C_OUT), 32'd0);
            bus.START = 1'b0;
            rst = 1'b0;
            dn = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                if (bus.DONE === 1'b1) dn++;
                if (bus.BUSY === 1'b1) dn++;
            end
            chk("midrst_no_done", 32'(dn), 32'd0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif

        repeat (3) begin @(posedge clk); #1; end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
